// File: rtl/fir_pkg.sv
// Shared definitions for the FIR sequencer slice.
//   state_e     - sequencer states
//   DEF_TAPS    - default number of CMEM coefficients
//   DEF_NSHIFT  - default samples shifted into IMEM per frame
//   DEF_ACC_W   - default MAC result width
package fir_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StFill,
    StMac,
    StOut
  } state_e;

  localparam int unsigned DEF_TAPS   = 64;
  localparam int unsigned DEF_NSHIFT = 8;
  localparam int unsigned DEF_ACC_W  = 32;

endpackage

// File: rtl/fir_tmo_cnt.sv
// Saturating up-counter used as the MAC watchdog.
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset
//   i_clr        - synchronous clear (priority over enable)
//   i_en         - count enable; holds once saturated
//   o_sat        - counter is at its all-ones value
module fir_tmo_cnt #(
  parameter int unsigned W = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_sat
);

  logic [W-1:0] r_cnt;

  assign o_sat = (r_cnt == {W{1'b1}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_sat) begin
      r_cnt <= r_cnt + W'(1);
    end
  end

endmodule

// File: rtl/fir_seq_ctrl.sv
// FIR datapath sequencer: loads CMEM coefficients, drains a frame of samples
// from the FIFO into IMEM, triggers the MAC with a watchdog, and presents the
// result on a valid/ready port.
// Ports:
//   clk, reset_n                        - clock, asynchronous active-low reset
//   start, coef_load                    - frame / coefficient-load request pulses
//   coef_wdata/wvalid/wready            - coefficient stream
//   cen, wen, addr, cmem_wdata          - CMEM write port
//   fifo_empty, read_enable, shift_enable - FIFO pop / IMEM shift
//   mac_start, done, result             - MAC control
//   out_data, out_valid, out_ready      - result handshake
//   busy, error                         - status (error is sticky timeout)
module fir_seq_ctrl
  import fir_pkg::*;
#(
  parameter int unsigned TAPS   = DEF_TAPS,
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned NSHIFT = DEF_NSHIFT,
  parameter int unsigned TMO_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              coef_load,
  input  logic [DATA_W-1:0] coef_wdata,
  input  logic              coef_wvalid,
  output logic              coef_wready,
  output logic              cen,
  output logic              wen,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] cmem_wdata,
  input  logic              fifo_empty,
  output logic              read_enable,
  output logic              shift_enable,
  output logic              mac_start,
  input  logic              done,
  input  logic [ACC_W-1:0]  result,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              error
);

  localparam int unsigned IDX_W = $clog2(TAPS + 1);
  localparam int unsigned CNT_W = $clog2(NSHIFT + 1);

  state_e            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_mac_start;
  logic              r_out_valid;
  logic [ACC_W-1:0]  r_out_data;
  logic              r_error;

  logic w_load;
  logic w_beat;
  logic w_pop;
  logic w_fill_last;
  logic w_tmo_en;
  logic w_tmo_sat;

  assign w_load      = (r_state == StLoad);
  assign w_beat      = w_load && coef_wvalid;
  assign w_pop       = (r_state == StFill) && !fifo_empty && (r_cnt < CNT_W'(NSHIFT));
  assign w_fill_last = w_pop && (r_cnt == CNT_W'(NSHIFT - 1));

  // Counting also on the edge into MAC makes the count equal the MAC cycle
  // number, so saturation lands on the (2**TMO_W-1)th MAC cycle.
  assign w_tmo_en = (r_state == StMac) || w_fill_last;

  fir_tmo_cnt #(
    .W(TMO_W)
  ) u_tmo (
    .clk    (clk),
    .reset_n(reset_n),
    .i_clr  (!w_tmo_en),
    .i_en   (w_tmo_en),
    .o_sat  (w_tmo_sat)
  );

  // CMEM strobes are gated by the registered state, so an async reset kills
  // any in-flight write in the same cycle.
  assign coef_wready  = w_load;
  assign cen          = w_beat;
  assign wen          = w_beat;
  assign addr         = w_load ? r_idx[ADDR_W-1:0] : '0;
  assign cmem_wdata   = w_load ? coef_wdata : '0;
  assign read_enable  = w_pop;
  assign shift_enable = w_pop;
  assign mac_start    = r_mac_start;
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign error        = r_error;
  assign busy         = (r_state != StIdle);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_mac_start <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_error     <= 1'b0;
    end else begin
      r_mac_start <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (coef_load) begin
            r_idx   <= '0;
            r_state <= StLoad;
          end else if (start) begin
            r_cnt   <= '0;
            r_state <= StFill;
          end
        end
        StLoad: begin
          if (coef_wvalid) begin
            if (r_idx == IDX_W'(TAPS - 1)) begin
              r_idx   <= '0;
              r_state <= StIdle;
            end else begin
              r_idx <= r_idx + IDX_W'(1);
            end
          end
        end
        StFill: begin
          if (w_pop) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_fill_last) begin
              r_mac_start <= 1'b1;
              r_state     <= StMac;
            end
          end
        end
        StMac: begin
          // done wins over a simultaneous timeout
          if (done) begin
            r_out_data  <= result;
            r_out_valid <= 1'b1;
            r_state     <= StOut;
          end else if (w_tmo_sat) begin
            r_error <= 1'b1;
            r_state <= StIdle;
          end
        end
        StOut: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed self-checking bench for fir_seq_ctrl.
module tb_fir_seq_ctrl;

  localparam int unsigned TAPS   = 64;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ACC_W  = 32;
  localparam int unsigned NSHIFT = 8;
  localparam int unsigned TMO_W  = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              coef_load;
  logic [DATA_W-1:0] coef_wdata;
  logic              coef_wvalid;
  logic              coef_wready;
  logic              cen;
  logic              wen;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] cmem_wdata;
  logic              fifo_empty;
  logic              read_enable;
  logic              shift_enable;
  logic              mac_start;
  logic              done;
  logic [ACC_W-1:0]  result;
  logic [ACC_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              error;

  int n_checks = 0;
  int n_errors = 0;
  int fifo_cnt = 0;
  int pops     = 0;

  always #5 clk = ~clk;

  fir_seq_ctrl #(
    .TAPS  (TAPS),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .ACC_W (ACC_W),
    .NSHIFT(NSHIFT),
    .TMO_W (TMO_W)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .coef_load   (coef_load),
    .coef_wdata  (coef_wdata),
    .coef_wvalid (coef_wvalid),
    .coef_wready (coef_wready),
    .cen         (cen),
    .wen         (wen),
    .addr        (addr),
    .cmem_wdata  (cmem_wdata),
    .fifo_empty  (fifo_empty),
    .read_enable (read_enable),
    .shift_enable(shift_enable),
    .mac_start   (mac_start),
    .done        (done),
    .result      (result),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy),
    .error       (error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; the FIFO model pops on any cycle read_enable was high.
  // Returns 2 time units after the edge, safely away from both clock edges.
  task automatic tick();
    if (read_enable) begin
      pops++;
      if (fifo_cnt > 0) fifo_cnt--;
    end
    @(posedge clk);
    #1;
    fifo_empty = (fifo_cnt == 0);
    #1;
  endtask

  task automatic set_fifo(input int n);
    fifo_cnt   = n;
    fifo_empty = (n == 0);
    #1;
  endtask

  task automatic run_to_mac(input string tag);
    int c;
    c = 0;
    while (!mac_start && c < 60) begin
      tick();
      c++;
    end
    check({tag, "_mac_start"}, 32'(mac_start), 32'd1);
  endtask

  task automatic start_frame(input int n);
    set_fifo(n);
    pops  = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_mac(input logic [31:0] val);
    done   = 1'b1;
    result = val;
    tick();
    done   = 1'b0;
    result = '0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int        n;
    int        bad;
    int        gap_bad;
    int        wr;
    int        c;
    logic [31:0] mask;
    logic        ov_seen;

    reset_n     = 1'b1;
    start       = 1'b0;
    coef_load   = 1'b0;
    coef_wdata  = '0;
    coef_wvalid = 1'b0;
    fifo_empty  = 1'b1;
    done        = 1'b0;
    result      = '0;
    out_ready   = 1'b0;
    #1 reset_n  = 1'b0;
    #12;

    // Reset state
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_strobes", {cen, wen, coef_wready, read_enable, shift_enable, mac_start}, 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    #1;

    // 1: coefficient load with two idle gaps
    coef_load = 1'b1;
    tick();
    coef_load = 1'b0;
    check("load_wready", 32'(coef_wready), 32'd1);
    bad = 0;
    gap_bad = 0;
    wr = 0;
    for (int i = 0; i < TAPS; i++) begin
      if (i == 10 || i == 40) begin
        coef_wvalid = 1'b0;
        #1;
        if (cen || wen) gap_bad++;
        tick();
      end
      coef_wvalid = 1'b1;
      coef_wdata  = 16'h0002;
      #1;
      if (cen && wen) wr++;
      if (addr != ADDR_W'(i) || cmem_wdata != 16'h0002) bad++;
      if (i == TAPS - 1) check("load_busy_last", 32'(busy), 32'd1);
      tick();
    end
    coef_wvalid = 1'b0;
    coef_wdata  = '0;
    #1;
    check("load_writes", wr, TAPS);
    check("load_addr_data", bad, 0);
    check("load_gap_idle", gap_bad, 0);
    check("load_busy_drop", 32'(busy), 32'd0);
    check("load_cen_after", 32'(cen), 32'd0);

    // 2: full frame, done after 20 MAC cycles
    start_frame(8);
    mask = '0;
    bad  = 0;
    c    = 0;
    while (c < 32 && !mac_start) begin
      if (read_enable) mask[c] = 1'b1;
      if (read_enable !== shift_enable) bad++;
      tick();
      c++;
    end
    check("fill_pop_mask", mask, 32'h0000_00FF);
    check("fill_shift_eq", bad, 0);
    check("fill_mac_cycle", c, 8);
    check("fill_mac_start", 32'(mac_start), 32'd1);
    tick();
    check("mac_start_width", 32'(mac_start), 32'd0);
    ov_seen = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (out_valid) ov_seen = 1'b1;
      tick();
    end
    finish_mac(32'd1234);
    check("frame_ov_early", 32'(ov_seen), 32'd0);
    check("frame_out_valid", 32'(out_valid), 32'd1);
    check("frame_out_data", out_data, 32'd1234);
    check("frame_pops", pops, 8);
    handshake();
    check("frame_ov_drop", 32'(out_valid), 32'd0);
    check("frame_idle", 32'(busy), 32'd0);

    // 3: FIFO runs dry for 5 cycles after 3 pops
    start_frame(3);
    for (int i = 0; i < 3; i++) tick();
    gap_bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (read_enable || shift_enable || !busy) gap_bad++;
      tick();
    end
    check("stall_enables_low", gap_bad, 0);
    set_fifo(5);
    run_to_mac("stall");
    check("stall_pops", pops, 8);
    finish_mac(32'h0000_ABCD);
    check("stall_out_data", out_data, 32'h0000_ABCD);
    handshake();

    // 4: MAC timeout, then a clean frame with error still set
    start_frame(8);
    run_to_mac("tmo");
    n = 0;
    ov_seen = 1'b0;
    while (busy && n < 400) begin
      if (out_valid) ov_seen = 1'b1;
      tick();
      n++;
    end
    check("tmo_cycles", n, 255);
    check("tmo_error", 32'(error), 32'd1);
    check("tmo_no_valid", 32'(ov_seen | out_valid), 32'd0);
    start_frame(8);
    run_to_mac("post_tmo");
    finish_mac(32'd77);
    check("post_tmo_valid", 32'(out_valid), 32'd1);
    check("post_tmo_data", out_data, 32'd77);
    check("post_tmo_error", 32'(error), 32'd1);
    handshake();

    // 5: back-pressure on the result port
    start_frame(8);
    run_to_mac("bp");
    finish_mac(32'h5A5A_0001);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!out_valid || out_data != 32'h5A5A_0001) bad++;
      tick();
    end
    check("bp_hold", bad, 0);
    handshake();
    check("bp_ov_drop", 32'(out_valid), 32'd0);

    // 6: coef_load beats start; then async reset mid-FILL
    start     = 1'b1;
    coef_load = 1'b1;
    tick();
    start     = 1'b0;
    coef_load = 1'b0;
    check("prio_load", 32'(coef_wready), 32'd1);
    check("prio_no_pop", 32'(read_enable), 32'd0);
    coef_wvalid = 1'b1;
    for (int i = 0; i < TAPS; i++) tick();
    coef_wvalid = 1'b0;
    #1;
    check("prio_load_done", 32'(busy), 32'd0);
    start_frame(8);
    tick();
    check("rst2_in_fill", 32'(read_enable), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst2_busy", 32'(busy), 32'd0);
    check("rst2_error", 32'(error), 32'd0);
    check("rst2_strobes", {read_enable, shift_enable, cen, coef_wready, mac_start, out_valid},
          32'd0);
    check("rst2_out_data", out_data, 32'd0);
    tick();
    reset_n = 1'b1;
    #1;
    check("rst2_idle", 32'(busy), 32'd0);
    start_frame(8);
    run_to_mac("rst2");
    check("rst2_pops", pops, 8);
    finish_mac(32'd5);
    handshake();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/fir_seq_ctrl.md
Name: fir_seq_ctrl

Overview:
Sequencer for the FIR datapath (input FIFO, IMEM shift register, CMEM coefficient store, MAC). Streams coefficients into CMEM and drains a frame of samples from the FIFO into IMEM. It then triggers the MAC, waits for done with a timeout, and hands the 32-bit result downstream on a valid/ready port. Sits between the host/config side and the datapath, in the datapath's slow clock domain.

Parameters:
TAPS, 64, number of CMEM coefficients
ADDR_W, 6, CMEM address width (log2 TAPS)
DATA_W, 16, coefficient/sample width
ACC_W, 32, MAC result width
NSHIFT, 8, FIFO samples shifted into IMEM per frame
TMO_W, 8, MAC timeout counter width; timeout = 2**TMO_W-1 cycles

Ports:
clk  in  1  single system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  pulse: run one filter frame
coef_load  in  1  pulse: begin coefficient load
coef_wdata  in  DATA_W  coefficient stream data
coef_wvalid  in  1  coefficient stream valid
coef_wready  out  1  coefficient stream ready
cen  out  1  CMEM enable, active-high
wen  out  1  CMEM write enable, active-high
addr  out  ADDR_W  CMEM address
cmem_wdata  out  DATA_W  CMEM write data
fifo_empty  in  1  datapath FIFO empty
read_enable  out  1  FIFO pop
shift_enable  out  1  IMEM shift
mac_start  out  1  one-cycle MAC trigger
done  in  1  MAC complete
result  in  ACC_W  MAC result
out_data  out  ACC_W  captured result
out_valid  out  1  result valid
out_ready  in  1  downstream accepts
busy  out  1  state != IDLE
error  out  1  sticky MAC timeout flag

Behaviour:
- Reset (async, reset_n=0): state IDLE, all counters 0, every output 0 (out_data=0, error=0). Reset mid-operation aborts immediately. No partial CMEM write survives the reset cycle.
- States: IDLE, LOAD, FILL, MAC, OUT. busy=1 in every state except IDLE.
- IDLE: coef_load -> LOAD. Otherwise start -> FILL. coef_load wins if both are high. start/coef_load in other states are ignored (not queued).
- LOAD: coef_wready=1. Each cycle with coef_wvalid: cen=1, wen=1, addr=idx, cmem_wdata=coef_wdata (combinational pass-through), idx++. The beat with idx=TAPS-1 is the last; next state IDLE, idx wraps to 0. coef_wvalid low leaves idx unchanged, so gaps are allowed.
- FILL: read_enable=shift_enable=!fifo_empty && cnt<NSHIFT, combinational, same cycle. cnt++ on each pop. Stalls indefinitely while the FIFO is empty. When cnt reaches NSHIFT, the next edge enters MAC with mac_start=1 for exactly that first MAC cycle.
- MAC: tmo counter increments each cycle. done=1 -> out_data<=result, out_valid<=1, next OUT. A done on the same cycle as tmo saturation counts as success. Saturation without done -> error<=1 (sticky until reset), next IDLE, no out_valid.
- OUT: out_valid held and out_data stable until out_ready. Handshake cycle -> out_valid<=0, next IDLE. out_ready is ignored when out_valid=0.
- Outside LOAD: cen=wen=0 and addr=0. Outside FILL: read_enable=shift_enable=0.
- Latency: start to first pop is 1 cycle. Last pop to mac_start is 1 cycle. done to out_valid is 1 cycle.
- Counters are sized to hold TAPS and NSHIFT without overflow.

Decomposition:
- Shared package fir_pkg: state enum (IDLE, LOAD, FILL, MAC, OUT) and default constants TAPS/NSHIFT/ACC_W.
- One natural sub-module, fir_tmo_cnt: clear/enable saturating counter with a sat flag, reused for the MAC timeout.
- Everything else is flat in fir_seq_ctrl.

Test Plan:
1. coef_load, then 64 beats of 16'h0002 with 2 idle gaps -> 64 write strobes, addr 0..63 in order, cmem_wdata=2, busy drops 1 cycle after beat 63.
2. FIFO preloaded with 8 samples, start -> 8 consecutive read_enable/shift_enable cycles, then a single mac_start pulse. Model done after 20 cycles with result=32'd1234 -> out_valid with out_data=1234.
3. FIFO empty for 5 cycles mid-frame (after 3 pops) -> enables low during the gap, total pops still exactly 8, mac_start after the 8th.
4. done never asserted -> after 255 MAC cycles error=1, out_valid never rises, state IDLE. A subsequent frame completes normally with error still 1.
5. out_ready low for 10 cycles -> out_valid and out_data held constant. One-cycle out_ready -> out_valid drops next cycle.
6. start and coef_load together in IDLE -> LOAD entered. Then reset_n pulsed low in FILL -> all outputs 0 asynchronously, IDLE after release.
